// File: rtl/serial_word_pkg.sv
// -----------------------------------------------------------------------------
// serial_word_pkg
// Shared definitions for the serial word receiver:
//   WORD_W_DEFAULT - default number of data bits per frame
//   rx_state_t     - receiver FSM states (PAR is used only when the
//                    SERIAL_WORD_RX_PARITY_EN build option is defined)
// -----------------------------------------------------------------------------
package serial_word_pkg;

    localparam int WORD_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } rx_state_t;

endpackage : serial_word_pkg

// File: rtl/serial_bit_counter.sv
// -----------------------------------------------------------------------------
// serial_bit_counter
// Counts accepted data bits 0..MAX_COUNT-1 and wraps to 0 after the last one.
// Ports:
//   Clk        - clock, all updates on posedge
//   Reset      - synchronous, active-high reset (count <= 0)
//   i_clear    - force the count to 0 (takes priority over i_inc)
//   i_inc      - advance the count by one, wrapping at the terminal value
//   o_count    - current count
//   o_terminal - count is at its last value (MAX_COUNT-1)
// -----------------------------------------------------------------------------
module serial_bit_counter #(
    parameter int MAX_COUNT = 16,
    parameter int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_terminal;

    assign w_terminal = (r_count == LAST);

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clk) begin
        if (Reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_terminal ? '0 : r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = w_terminal;

endmodule : serial_bit_counter

// File: rtl/serial_word_rx.sv
// -----------------------------------------------------------------------------
// serial_word_rx
// Assembles LSB-first serial bits into WORD_W-bit words and presents them on a
// valid/ready output with sticky overrun reporting.
// Build option: SERIAL_WORD_RX_PARITY_EN - when defined, each frame carries an
// even-parity bit after the data bits; a parity mismatch drops the word and
// pulses Parity_Err. When undefined, Parity_Err is tied to 0.
// Ports:
//   Clk, Reset  - clock and synchronous active-high reset
//   Bit_In      - serial data bit, sampled when Bit_Valid=1
//   Bit_Valid   - Bit_In is valid on this edge
//   Abort       - discard the partial frame and return to IDLE
//   Data_Ready  - consumer accepts Data_Out this cycle
//   Clr_Ovr     - clear the sticky Overrun flag
//   Data_Out    - last delivered word
//   Data_Valid  - Data_Out holds an unconsumed word
//   Overrun     - sticky: a completed word was dropped for lack of space
//   Parity_Err  - one-cycle pulse on a parity failure
//   Busy        - a frame is in progress
// -----------------------------------------------------------------------------
module serial_word_rx
    import serial_word_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Bit_In,
    input  logic              Bit_Valid,
    input  logic              Abort,
    input  logic              Data_Ready,
    input  logic              Clr_Ovr,
    output logic [WORD_W-1:0] Data_Out,
    output logic              Data_Valid,
    output logic              Overrun,
    output logic              Parity_Err,
    output logic              Busy
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    rx_state_t         r_state;
    rx_state_t         w_next_state;
    logic [WORD_W-1:0] r_sr;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;
    logic [CNT_W-1:0]  w_count;
    logic              w_terminal;
    logic              w_bit_acc;   // bit accepted (Abort discards it)
    logic              w_shift;     // accepted bit is a data bit
    logic              w_deliver;   // completed frame carries a good word
    logic [WORD_W-1:0] w_word;      // word offered on completion
    logic              w_busy;

    assign w_bit_acc = Bit_Valid && !Abort;
    assign w_shift   = w_bit_acc && (r_state != PAR);

    serial_bit_counter #(
        .MAX_COUNT (WORD_W),
        .CNT_W     (CNT_W)
    ) u_bit_counter (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_clear    (Abort),
        .i_inc      (w_shift),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

`ifdef SERIAL_WORD_RX_PARITY_EN
    logic w_par_done;
    logic r_par_err;

    // The parity bit ends the frame; the data is already fully in r_sr.
    assign w_par_done = w_bit_acc && (r_state == PAR);
    assign w_word     = r_sr;
    assign w_deliver  = w_par_done && (Bit_In == ^r_sr);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_done && (Bit_In != ^r_sr);
        end
    end

    assign Parity_Err = r_par_err;
`else
    // The last data bit ends the frame; fold it in combinationally so the
    // word is registered on the same edge that samples it.
    assign w_word     = {Bit_In, r_sr[WORD_W-1:1]};
    assign w_deliver  = w_shift && w_terminal;
    assign Parity_Err = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: assign a default before the case so every path drives
    // w_next_state; a missing path would infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (Abort) begin
            w_next_state = IDLE;
        end else if (Bit_Valid) begin
            case (r_state)
                IDLE, SHIFT: begin
                    if (w_terminal) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
                        w_next_state = PAR;
`else
                        w_next_state = IDLE;
`endif
                    end else begin
                        w_next_state = SHIFT;
                    end
                end
                default: w_next_state = IDLE;   // parity bit closes the frame
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy = (r_state != IDLE);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sr <= '0;
        end else if (w_shift) begin
            r_sr <= {Bit_In, r_sr[WORD_W-1:1]};
        end
    end

    // A completed word loads if the output slot is free or being consumed
    // on this same edge; otherwise it is dropped and flagged.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_deliver && (!r_valid || Data_Ready)) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && Data_Ready) begin
                r_valid <= 1'b0;
            end

            // A new overrun outranks a simultaneous clear.
            if (w_deliver && r_valid && !Data_Ready) begin
                r_overrun <= 1'b1;
            end else if (Clr_Ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign Data_Out   = r_data;
    assign Data_Valid = r_valid;
    assign Overrun    = r_overrun;
    assign Busy       = w_busy;

endmodule : serial_word_rx

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 Parameter WORD_W, default 16, meaning: data bits per frame.
REQ-002 Clk  input  1  clock; all state updates on posedge Clk.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Bit_In  input  1  serial data bit, LSB of the word first.
REQ-005 Bit_Valid  input  1  Bit_In is sampled on this edge.
REQ-006 Abort  input  1  discard the partial frame and return to IDLE.
REQ-007 Data_Ready  input  1  consumer accepts Data_Out this cycle.
REQ-008 Clr_Ovr  input  1  clears the sticky Overrun flag.
REQ-009 Data_Out  output  WORD_W  last completed word.
REQ-010 Data_Valid  output  1  Data_Out holds an unconsumed word.
REQ-011 Overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 Parity_Err  output  1  one-cycle pulse: a frame failed parity.
REQ-013 Busy  output  1  a frame is in progress (state is not IDLE).

Function
REQ-014 Internal shift register: on each accepted bit, sr <= {Bit_In, sr[WORD_W-1:1]}; the first received bit ends in sr[0].
REQ-015 FSM states: IDLE, SHIFT, PAR (PAR exists only with the macro); no other states.
REQ-016 IDLE -> SHIFT on the first Bit_Valid; that bit is counted as bit 0.
REQ-017 Bit counter counts 0..WORD_W-1 and wraps to 0 on frame completion; Bit_In is ignored when Bit_Valid=0.
REQ-018 Without the macro, the WORD_W-th accepted bit completes the frame; the FSM returns to IDLE on the same edge.
REQ-019 On completion, Data_Out <= assembled word and Data_Valid <= 1 on the same edge that samples the final bit.
REQ-020 Latency from the final Bit_Valid edge to Data_Valid high is zero cycles (registered output, visible after that edge).
REQ-021 Data_Valid and Data_Out hold until a cycle with Data_Valid=1 and Data_Ready=1; Data_Valid then clears on the next edge.
REQ-022 A frame completing while Data_Valid=1 and Data_Ready=0: the new word is dropped, Data_Out is unchanged, Overrun <= 1.
REQ-023 A frame completing while Data_Valid=1 and Data_Ready=1: the new word loads, Data_Valid stays 1, no overrun.
REQ-024 Overrun stays 1 until Clr_Ovr; if Clr_Ovr and a new overrun occur on the same edge, the overrun wins.
REQ-025 Abort has priority over Bit_Valid: the counter clears, the FSM goes to IDLE, and the bit is discarded; Data_Out and Data_Valid are unaffected.
REQ-026 Reception continues while Data_Valid=1; there is no backpressure on the serial side.

Reset
REQ-027 When Reset=1: FSM <= IDLE, counter <= 0, sr <= 0, Data_Out <= 0, Data_Valid <= 0, Overrun <= 0, Parity_Err <= 0.
REQ-028 Reset overrides all other inputs; a frame in progress when Reset asserts is lost and not reported.

Configuration
REQ-029 Macro SERIAL_WORD_RX_PARITY_EN defined: after WORD_W data bits the FSM enters PAR; the next accepted bit is an even-parity bit over the data.
REQ-030 With the macro, a parity match delivers the word per REQ-019..023; a mismatch drops the word and pulses Parity_Err for one cycle.
REQ-031 Macro undefined: the PAR state is absent and Parity_Err is tied to 0.

Structure
REQ-032 Shared package serial_word_pkg holds WORD_W_DEFAULT=16 and the rx_state_t enum (IDLE, SHIFT, PAR).
REQ-033 One sub-module, serial_bit_counter, provides the clear, increment, and terminal-count flag.

Verification
REQ-034 Reset, then send 0xA5C3 LSB-first with one idle cycle between bits -> Data_Out=0xA5C3, Data_Valid=1 after bit 15, Busy=0.
REQ-035 Send 0x1234, hold Data_Ready=0, send 0xFFFF -> Data_Out stays 0x1234, Overrun=1; Clr_Ovr -> Overrun=0.
REQ-036 Send 0x0001 with Data_Ready=1 asserted on the edge the next word 0x8000 completes -> Data_Out=0x8000, Data_Valid=1, Overrun=0.
REQ-037 Send 7 bits, Abort together with the 8th Bit_Valid, then send 0x00FF -> Data_Out=0x00FF.
REQ-038 Assert Reset after 10 bits -> all outputs 0; then send 0xBEEF -> Data_Out=0xBEEF.
REQ-039 With the macro, send 0x0003 with parity bit 1 -> Parity_Err pulses once, Data_Valid=0; repeat with parity bit 0 -> Data_Out=0x0003.
